// File: rtl/mix_tree_pkg.sv
// mix_tree_pkg -- shared types and helpers for the mixing-tree controller.
//
// Contents:
//   state_t          controller FSM states
//   level_first_idx  heap index of the first mixer on tree level l (2**l - 1)
//   level_count      number of mixers on tree level l (2**l)
//
// Levels are numbered from the root: level 0 is the single root mixer,
// level DEPTH-1 is the bottom row that is fed directly by the leaves.

package mix_tree_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MIX   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int level_first_idx(input int l);
        return (1 << l) - 1;
    endfunction

    function automatic int level_count(input int l);
        return 1 << l;
    endfunction

endpackage

// File: rtl/mix_tree_cycle_timer.sv
// mix_tree_cycle_timer -- loadable down-counter with an expiry flag.
//
// Ports:
//   clk         rising-edge clock
//   srst        synchronous active-high reset (clears the count)
//   load        load load_value into the counter this edge
//   load_value  value to load; a phase of N cycles loads N-1
//   expired     high while the count is zero (last cycle of a phase)
//
// The counter saturates at zero so it can sit idle between phases.

module mix_tree_cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expired
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/mix_tree_ctrl.sv
// mix_tree_ctrl -- sequencer for a binary mixing tree.
//
// A run loads the selected leaf inlets, then mixes level by level from the
// bottom row up to the root, then flushes through the outlet and pulses done.
//
// Parameters:
//   DEPTH        number of tree levels (LEAVES = 2**DEPTH, MIXERS = LEAVES-1)
//   LOAD_CYCLES  cycles of the load phase and of the flush phase (>= 1)
//   MIX_CYCLES   cycles spent on each mixing level (>= 1)
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start_i       request a run (only honoured in IDLE with a nonzero mask)
//   abort_i       cancel the current run (only with MIX_TREE_CTRL_ABORT_EN)
//   in_mask_i     participating leaves, captured at start
//   load_valve_o  inlet valve enables (captured mask during LOAD)
//   mix_en_o      mixer enables in heap order, bit 0 = root
//   out_valve_o   outlet valve enable (FLUSH)
//   level_o       current mixing level (DEPTH-1 = bottom, 0 = root)
//   busy_o        high in any state other than IDLE
//   done_o        one-cycle pulse at run completion
//
// Build option: define MIX_TREE_CTRL_ABORT_EN to make abort_i effective.
// Without it abort_i is accepted but has no effect.
//
// All outputs are registered copies derived from the next-state values, so
// they change on the same edge as the state and never combinationally
// depend on the inputs.

module mix_tree_ctrl
    import mix_tree_pkg::*;
#(
    parameter int DEPTH       = 3,
    parameter int LOAD_CYCLES = 8,
    parameter int MIX_CYCLES  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [(2**DEPTH)-1:0]        in_mask_i,
    output logic [(2**DEPTH)-1:0]        load_valve_o,
    output logic [(2**DEPTH)-2:0]        mix_en_o,
    output logic                         out_valve_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int LEAVES = 2 ** DEPTH;
    localparam int MIXERS = LEAVES - 1;
    localparam int LW     = $clog2(DEPTH + 1);
    localparam int TMAX   = (LOAD_CYCLES > MIX_CYCLES) ? LOAD_CYCLES : MIX_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);

    state_t              state_reg, state_next;
    logic [LW-1:0]       level_reg, level_next;
    logic [LEAVES-1:0]   mask_reg, mask_next;

    logic                tmr_load;
    logic [TW-1:0]       tmr_value;
    logic                tmr_expired;

    logic [LEAVES-1:0]   load_valve_reg;
    logic [MIXERS-1:0]   mix_en_reg;
    logic                out_valve_reg;
    logic                busy_reg;
    logic                done_reg;

    logic [MIXERS-1:0]   mix_active;

    mix_tree_cycle_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .srst       (rst),
        .load       (tmr_load),
        .load_value (tmr_value),
        .expired    (tmr_expired)
    );

`ifndef MIX_TREE_CTRL_ABORT_EN
    logic unused_abort;
    assign unused_abort = abort_i;
`endif

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        mask_next  = mask_reg;
        tmr_load   = 1'b0;
        tmr_value  = '0;

        case (state_reg)
            ST_IDLE: begin
                if (start_i && (|in_mask_i)) begin
                    state_next = ST_LOAD;
                    mask_next  = in_mask_i;
                    tmr_load   = 1'b1;
                    tmr_value  = TW'(LOAD_CYCLES - 1);
                end
            end
            ST_LOAD: begin
                if (tmr_expired) begin
                    state_next = ST_MIX;
                    level_next = LW'(DEPTH - 1);
                    tmr_load   = 1'b1;
                    tmr_value  = TW'(MIX_CYCLES - 1);
                end
            end
            ST_MIX: begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    if (level_reg == '0) begin
                        state_next = ST_FLUSH;
                        tmr_value  = TW'(LOAD_CYCLES - 1);
                    end else begin
                        level_next = level_reg - LW'(1);
                        tmr_value  = TW'(MIX_CYCLES - 1);
                    end
                end
            end
            ST_FLUSH: begin
                if (tmr_expired) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                level_next = '0;
                mask_next  = '0;
            end
            default: begin
                state_next = ST_IDLE;
                level_next = '0;
                mask_next  = '0;
            end
        endcase

`ifdef MIX_TREE_CTRL_ABORT_EN
        if (abort_i && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
            level_next = '0;
            mask_next  = '0;
            tmr_load   = 1'b0;
        end
`endif
    end

    // A mixer on level gi, position gj, sits above the contiguous leaf
    // range [gj*SPAN, (gj+1)*SPAN). It runs only when its level is active
    // and at least one leaf in that range was loaded.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_level
            for (genvar gj = 0; gj < level_count(gi); gj++) begin : g_node
                localparam int NODE = level_first_idx(gi) + gj;
                localparam int SPAN = 1 << (DEPTH - gi);
                localparam int LO   = gj * SPAN;
                assign mix_active[NODE] = (level_next == LW'(gi)) &&
                                          (|mask_next[LO +: SPAN]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            level_reg      <= '0;
            mask_reg       <= '0;
            load_valve_reg <= '0;
            mix_en_reg     <= '0;
            out_valve_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            level_reg      <= level_next;
            mask_reg       <= mask_next;
            load_valve_reg <= (state_next == ST_LOAD) ? mask_next : '0;
            mix_en_reg     <= (state_next == ST_MIX) ? mix_active : '0;
            out_valve_reg  <= (state_next == ST_FLUSH);
            busy_reg       <= (state_next != ST_IDLE);
            done_reg       <= (state_next == ST_DONE);
        end
    end

    assign load_valve_o = load_valve_reg;
    assign mix_en_o     = mix_en_reg;
    assign out_valve_o  = out_valve_reg;
    assign level_o      = level_reg;
    assign busy_o       = busy_reg;
    assign done_o       = done_reg;

endmodule

// File: tb/tb_mix_tree_ctrl.sv
// tb_mix_tree_ctrl -- directed scoreboard bench for mix_tree_ctrl
// (DEPTH=3, LOAD_CYCLES=2, MIX_CYCLES=4). Expected per-cycle outputs are
// queued when a run is set up and popped one per clock as the DUT advances.

module tb_mix_tree_ctrl;

    localparam int D  = 3;
    localparam int LC = 2;
    localparam int MC = 4;
    localparam int RUN_LEN = 2 * LC + D * MC + 1;   // done cycle

    typedef struct packed {
        logic [7:0] load;
        logic [6:0] mix;
        logic       outv;
        logic       busy;
        logic       done;
        logic       chk_lvl;
        logic [1:0] lvl;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic       abort_i;
    logic [7:0] in_mask_i;
    logic [7:0] load_valve_o;
    logic [6:0] mix_en_o;
    logic       out_valve_o;
    logic [1:0] level_o;
    logic       busy_o;
    logic       done_o;

    exp_t exp_q[$];
    int   compared;
    int   mismatched;
    int   cyc;

    mix_tree_ctrl #(
        .DEPTH       (D),
        .LOAD_CYCLES (LC),
        .MIX_CYCLES  (MC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .in_mask_i    (in_mask_i),
        .load_valve_o (load_valve_o),
        .mix_en_o     (mix_en_o),
        .out_valve_o  (out_valve_o),
        .level_o      (level_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Walk each loaded leaf up the heap to the requested level.
    function automatic logic [6:0] model_mix(input logic [7:0] m, input int lvl);
        logic [6:0] r;
        int n;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                n = (2 ** (D - 1)) - 1 + i / 2;
                for (int l = D - 1; l > lvl; l--) n = (n - 1) / 2;
                r[n] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic push_idle(input int n);
        exp_t e;
        e = '0;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // Expected outputs for run cycles 1..ncyc after start sampled in cycle 0.
    task automatic push_run(input logic [7:0] m, input int ncyc);
        exp_t e;
        int lvl;
        for (int c = 1; c <= ncyc; c++) begin
            e = '0;
            e.busy = 1'b1;
            if (c <= LC) begin
                e.load = m;
            end else if (c <= LC + D * MC) begin
                lvl       = D - 1 - (c - LC - 1) / MC;
                e.mix     = model_mix(m, lvl);
                e.chk_lvl = 1'b1;
                e.lvl     = 2'(lvl);
            end else if (c <= 2 * LC + D * MC) begin
                e.outv = 1'b1;
            end else begin
                e.done = 1'b1;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        compared++;
        assert (obs === exp_v)
        else begin
            mismatched++;
            $error("FAIL %s cycle %0d: observed %h, expected %h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        check("load_valve", load_valve_o, e.load);
        check("mix_en", {1'b0, mix_en_o}, e.mix);
        check("out_valve", {7'b0, out_valve_o}, {7'b0, e.outv});
        check("busy", {7'b0, busy_o}, {7'b0, e.busy});
        check("done", {7'b0, done_o}, {7'b0, e.done});
        if (e.chk_lvl) check("level", {6'b0, level_o}, {6'b0, e.lvl});
    endtask

    // Drive one scenario until the queued expectations are consumed.
    // Event times are the cycle in which the input is held high; -1 = never.
    task automatic run_test(input string name, input logic [7:0] m, input int pulse_at,
                            input int abort_at, input int rst_at, input int restart_at);
        int c;
        int errs_before;
        errs_before = mismatched;
        cyc = 0;
        c = 0;
        in_mask_i = m;
        while (exp_q.size() > 0) begin
            start_i = (c == 0) || (c == pulse_at) || (c == restart_at);
            abort_i = (c == abort_at);
            rst     = (c == rst_at);
            step();
            c++;
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        rst     = 1'b0;
        $display("run %-12s mask=%h cycles=%0d new_mismatches=%0d", name, m, c,
                 mismatched - errs_before);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        rst        = 1'b1;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        in_mask_i  = 8'h00;

        // Reset state, with a start request held to show reset has priority.
        start_i   = 1'b1;
        in_mask_i = 8'hFF;
        push_idle(2);
        step();
        step();
        start_i = 1'b0;
        rst     = 1'b0;
        push_idle(1);
        step();
        $display("run %-12s checked reset state", "reset");

        // Full mask: complete run with exact phase timing.
        push_run(8'hFF, RUN_LEN);
        push_idle(2);
        run_test("full_mask", 8'hFF, -1, -1, -1, -1);

        // Two adjacent leaves: only the mixers above leaves 0/1 run.
        push_run(8'h03, RUN_LEN);
        push_idle(2);
        run_test("mask_03", 8'h03, -1, -1, -1, -1);

        // Sparse mask, one leaf per bottom mixer pair in the upper half.
        push_run(8'hA0, RUN_LEN);
        push_idle(2);
        run_test("mask_a0", 8'hA0, -1, -1, -1, -1);

        // Start with an empty mask is ignored.
        push_idle(4);
        run_test("zero_mask", 8'h00, -1, -1, -1, -1);

        // A second start while busy changes nothing; exactly one done.
        push_run(8'hFF, RUN_LEN);
        push_idle(3);
        run_test("start_busy", 8'hFF, 5, -1, -1, -1);

        // Abort in cycle 8.
`ifdef MIX_TREE_CTRL_ABORT_EN
        push_run(8'hFF, 8);
        push_idle(4);
`else
        push_run(8'hFF, RUN_LEN);
        push_idle(2);
`endif
        run_test("abort", 8'hFF, -1, 8, -1, -1);

        // Reset mid-run, then a fresh run started in cycle 14.
        push_run(8'hFF, 12);
        push_idle(2);
        push_run(8'hFF, RUN_LEN);
        push_idle(2);
        run_test("reset_mid", 8'hFF, -1, -1, 12, 14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mix_tree_ctrl.md
MIX_TREE_CTRL -- requirements
Module: mix_tree_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-002 The block SHALL have parameter DEPTH, default 3, number of tree levels; LEAVES=2**DEPTH inputs, MIXERS=LEAVES-1.
REQ-003 The block SHALL have parameter LOAD_CYCLES, default 8, cycles per load phase and per flush phase (>=1).
REQ-004 The block SHALL have parameter MIX_CYCLES, default 16, cycles per mixing level (>=1).
REQ-005 The block SHALL have port start_i, input, 1 bit, request one mixing run; sampled only in IDLE.
REQ-006 The block SHALL have port abort_i, input, 1 bit, cancel the current run.
REQ-007 The block SHALL have port in_mask_i, input, LEAVES bits, inputs participating in the run; captured at start.
REQ-008 The block SHALL have port load_valve_o, output, LEAVES bits, inlet valve enables.
REQ-009 The block SHALL have port mix_en_o, output, MIXERS bits, mixer enables in heap order (bit 0 = root; children of node n are 2n+1 and 2n+2).
REQ-010 The block SHALL have port out_valve_o, output, 1 bit, outlet valve enable.
REQ-011 The block SHALL have port level_o, output, $clog2(DEPTH+1) bits, current mixing level (DEPTH-1 = bottom, 0 = root).
REQ-012 The block SHALL have port busy_o, output, 1 bit, high in any state other than IDLE.
REQ-013 The block SHALL have port done_o, output, 1 bit, single-cycle pulse on run completion.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, MIX, FLUSH, DONE.
REQ-015 IDLE->LOAD SHALL occur on start_i=1 with nonzero mask; start_i with mask 0 SHALL be ignored.
REQ-016 LOAD SHALL assert load_valve_o=captured mask for exactly LOAD_CYCLES cycles, then go to MIX with level=DEPTH-1.
REQ-017 MIX SHALL hold each level for MIX_CYCLES cycles, driving mix_en_o high only for mixers at that level with at least one masked-in leaf below them.
REQ-018 Leaf i SHALL feed mixer index 2**(DEPTH-1)-1+i/2.
REQ-019 After level 0 completes, MIX->FLUSH SHALL occur; FLUSH SHALL assert out_valve_o for LOAD_CYCLES cycles, then go to DONE.
REQ-020 DONE SHALL assert done_o for one cycle, then return to IDLE.
REQ-021 Latency: with start_i sampled in cycle 0, done_o SHALL be high in cycle 2*LOAD_CYCLES+DEPTH*MIX_CYCLES+1.
REQ-022 start_i while busy SHALL be ignored.
REQ-023 In IDLE and DONE, all valve and mixer outputs SHALL be 0.
REQ-024 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-025 rst SHALL force IDLE, clear all outputs, the counter and the captured mask on the next edge, including mid-run; no done_o SHALL be generated.
REQ-026 rst SHALL take priority over abort_i and start_i.

Configuration
REQ-027 With ABORT support compiled in via macro MIX_TREE_CTRL_ABORT_EN, abort_i=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge with all outputs 0 and no done_o.
REQ-028 Without MIX_TREE_CTRL_ABORT_EN, abort_i SHALL be present but ignored, and every started run SHALL complete.

Structure
REQ-029 Package mix_tree_pkg SHALL hold the state enum, and level-to-mixer-index helper functions that compute the first index (2**l-1) and the count (2**l).
REQ-030 Sub-module mix_tree_cycle_timer (loadable down-counter with an expiry flag) SHALL time the LOAD, MIX and FLUSH phases.

Verification (DEPTH=3, LOAD_CYCLES=2, MIX_CYCLES=4)
REQ-031 The bench SHALL check: start, mask 8'hFF -> load_valve_o=8'hFF in cycles 1-2; mix_en_o=7'h78 in cycles 3-6, 7'h06 in cycles 7-10, 7'h01 in cycles 11-14; out_valve_o in cycles 15-16; done_o in cycle 17.
REQ-032 The bench SHALL check: mask 8'h03 -> load 8'h03; mix_en_o sequence 7'h08, 7'h02, 7'h01; same timing as REQ-031.
REQ-033 The bench SHALL check: start with mask 8'h00 -> busy_o stays 0 and no output activity.
REQ-034 The bench SHALL check: start_i pulsed in cycle 5 of a run -> no effect, done_o still in cycle 17, exactly one done_o.
REQ-035 The bench SHALL check: abort_i in cycle 8 -> with MIX_TREE_CTRL_ABORT_EN, outputs 0 and busy_o 0 from cycle 9 with no done_o; without the macro, behaviour identical to REQ-031.
REQ-036 The bench SHALL check: rst in cycle 12 -> all outputs 0 from cycle 13; a new start in cycle 14 completes normally with done_o in cycle 31.
